// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC error monitor slice.
// Error-type codes, monitor state encoding and default widths live here.
package ecc_pkg;

  localparam int DEF_DATA_WIDTH = 119;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SBIT  = 2'd1;
  localparam logic [1:0] ERR_DBIT  = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOGGED = 1'b1
  } mon_state_t;

  // Most severe error wins when several flags arrive together.
  function automatic logic [1:0] err_type_sel(input logic f, input logic d, input logic s);
    logic [1:0] t;
    t = ERR_NONE;
    if (f)      t = ERR_FAULT;
    else if (d) t = ERR_DBIT;
    else if (s) t = ERR_SBIT;
    return t;
  endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter with synchronous clear.
// A clear in the same cycle as an increment leaves the count at one.
module ecc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_ONE : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/ecc_119_err_monitor.sv
// Downstream monitor of the 119-bit ECC path: registers corrected data,
// counts qualified errors, records the first error and raises a level irq.
module ecc_119_err_monitor
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic                  clr,
  input  logic [2:0]            irq_en,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_poison,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [2:0]            err_sticky,
  output logic [ADDR_WIDTH-1:0] first_addr,
  output logic [1:0]            first_type,
  output logic                  irq
);

  logic       q_s, q_d, q_f, q_any;
  logic [2:0] q_vec;
  logic [2:0] sticky_next;
  logic       capture;
  logic [1:0] capture_type;

  mon_state_t state, state_next;

  assign q_s   = sbit_err  & in_vld;
  assign q_d   = dbit_err  & in_vld;
  assign q_f   = ecc_fault & in_vld;
  assign q_any = q_s | q_d | q_f;
  assign q_vec = {q_f, q_d, q_s};

  // Clear is applied before the same-cycle event, so the event survives it.
  assign sticky_next = (clr ? 3'b000 : err_sticky) | q_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_poison <= 1'b0;
    end else begin
      out_vld    <= in_vld;
      out_poison <= q_d | q_f;
      if (in_vld) begin
        out_data <= data_in;
      end
    end
  end

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_sbit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (q_s),
    .cnt   (sbit_cnt)
  );

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_dbit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (q_d),
    .cnt   (dbit_cnt)
  );

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_fault_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (q_f),
    .cnt   (fault_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 3'b000;
      irq        <= 1'b0;
    end else begin
      err_sticky <= sticky_next;
      irq        <= |(sticky_next & irq_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A clear makes the monitor behave as if idle for this cycle's event.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = q_any ? LOGGED : IDLE;
    end else if ((state == IDLE) && q_any) begin
      state_next = LOGGED;
    end
  end

  always_comb begin
    capture      = q_any && ((state == IDLE) || clr);
    capture_type = err_type_sel(q_f, q_d, q_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_addr <= '0;
      first_type <= ERR_NONE;
    end else if (capture) begin
      first_addr <= in_addr;
      first_type <= capture_type;
    end else if (clr) begin
      first_addr <= '0;
      first_type <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_ecc_119_err_monitor.sv
// Directed self-checking bench for ecc_119_err_monitor, built with
// 4-bit counters so saturation is reachable in a few cycles.
module tb_ecc_119_err_monitor;

  localparam int DW = 119;
  localparam int AW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_vld;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] data_in;
  logic          sbit_err, dbit_err, ecc_fault;
  logic          clr;
  logic [2:0]    irq_en;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_poison;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [2:0]    err_sticky;
  logic [AW-1:0] first_addr;
  logic [1:0]    first_type;
  logic          irq;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] pat_5a;
  logic [DW-1:0] pat_c3;

  ecc_119_err_monitor #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .in_addr    (in_addr),
    .data_in    (data_in),
    .sbit_err   (sbit_err),
    .dbit_err   (dbit_err),
    .ecc_fault  (ecc_fault),
    .clr        (clr),
    .irq_en     (irq_en),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_poison (out_poison),
    .sbit_cnt   (sbit_cnt),
    .dbit_cnt   (dbit_cnt),
    .fault_cnt  (fault_cnt),
    .err_sticky (err_sticky),
    .first_addr (first_addr),
    .first_type (first_type),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic vld, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic s, input logic d, input logic f, input logic c);
    in_vld    = vld;
    in_addr   = addr;
    data_in   = data;
    sbit_err  = s;
    dbit_err  = d;
    ecc_fault = f;
    clr       = c;
    @(posedge clk);
    #1;
    in_vld    = 1'b0;
    sbit_err  = 1'b0;
    dbit_err  = 1'b0;
    ecc_fault = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic checkCounts(input string tag, input logic [CW-1:0] s, input logic [CW-1:0] d, input logic [CW-1:0] f);
    checkOutput({tag, "_sbit_cnt"},  128'(sbit_cnt),  128'(s));
    checkOutput({tag, "_dbit_cnt"},  128'(dbit_cnt),  128'(d));
    checkOutput({tag, "_fault_cnt"}, 128'(fault_cnt), 128'(f));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pat_5a = DW'({15{8'h5A}});
    pat_c3 = DW'({15{8'hC3}});
    rst_n = 1'b0;
    irq_en = 3'b000;
    in_vld = 1'b0; in_addr = '0; data_in = '0;
    sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0; clr = 1'b0;

    // Reset state, with flags asserted to prove reset dominates
    applyStimulus(1'b1, 8'hFF, pat_c3, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, pat_c3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_out_vld",    128'(out_vld),    128'(0));
    checkOutput("rst_out_data",   128'(out_data),   128'(0));
    checkOutput("rst_out_poison", 128'(out_poison), 128'(0));
    checkCounts("rst", 4'd0, 4'd0, 4'd0);
    checkOutput("rst_sticky",     128'(err_sticky), 128'(0));
    checkOutput("rst_first_addr", 128'(first_addr), 128'(0));
    checkOutput("rst_first_type", 128'(first_type), 128'(0));
    checkOutput("rst_irq",        128'(irq),        128'(0));
    rst_n = 1'b1;

    // Clean word passes through
    applyStimulus(1'b1, 8'h00, pat_5a, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_out_vld",    128'(out_vld),    128'(1));
    checkOutput("clean_out_data",   128'(out_data),   128'(pat_5a));
    checkOutput("clean_out_poison", 128'(out_poison), 128'(0));
    checkCounts("clean", 4'd0, 4'd0, 4'd0);
    checkOutput("clean_irq",        128'(irq),        128'(0));

    // Unqualified flags have no effect; data holds
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'hEE, pat_c3, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("novld_out_vld",    128'(out_vld),    128'(0));
    checkOutput("novld_out_data",   128'(out_data),   128'(pat_5a));
    checkOutput("novld_out_poison", 128'(out_poison), 128'(0));
    checkCounts("novld", 4'd0, 4'd0, 4'd0);
    checkOutput("novld_sticky",     128'(err_sticky), 128'(0));
    checkOutput("novld_first_type", 128'(first_type), 128'(0));

    // First sbit captured, later dbit only counted
    applyStimulus(1'b1, 8'h12, pat_c3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sb_out_data",   128'(out_data),   128'(pat_c3));
    checkOutput("sb_out_poison", 128'(out_poison), 128'(0));
    checkOutput("sb_first_addr", 128'(first_addr), 128'(8'h12));
    checkOutput("sb_first_type", 128'(first_type), 128'(1));
    checkOutput("sb_sticky",     128'(err_sticky), 128'(3'b001));
    applyStimulus(1'b1, 8'h34, pat_5a, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("db_out_poison", 128'(out_poison), 128'(1));
    checkOutput("db_first_addr", 128'(first_addr), 128'(8'h12));
    checkOutput("db_first_type", 128'(first_type), 128'(1));
    checkCounts("db", 4'd1, 4'd1, 4'd0);
    checkOutput("db_sticky",     128'(err_sticky), 128'(3'b011));
    checkOutput("db_irq",        128'(irq),        128'(0));

    // Plain clear
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCounts("clr1", 4'd0, 4'd0, 4'd0);
    checkOutput("clr1_sticky",     128'(err_sticky), 128'(0));
    checkOutput("clr1_first_addr", 128'(first_addr), 128'(0));
    checkOutput("clr1_first_type", 128'(first_type), 128'(0));

    // Fault interrupt path
    irq_en = 3'b100;
    applyStimulus(1'b1, 8'h07, pat_5a, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flt_irq",        128'(irq),        128'(1));
    checkOutput("flt_first_type", 128'(first_type), 128'(3));
    checkOutput("flt_first_addr", 128'(first_addr), 128'(8'h07));
    checkOutput("flt_poison",     128'(out_poison), 128'(1));
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flt_irq_hold",   128'(irq),        128'(1));
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("flt_clr_irq",    128'(irq),        128'(0));
    checkCounts("flt_clr", 4'd0, 4'd0, 4'd0);
    // Back in IDLE: new error captured; sbit not enabled for irq
    applyStimulus(1'b1, 8'h55, pat_5a, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_first_addr", 128'(first_addr), 128'(8'h55));
    checkOutput("idle_first_type", 128'(first_type), 128'(1));
    checkOutput("idle_irq_masked", 128'(irq),        128'(0));

    // irq drops when its enable is removed
    applyStimulus(1'b1, 8'h56, pat_5a, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("en_irq_on",  128'(irq), 128'(1));
    irq_en = 3'b000;
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("en_irq_off", 128'(irq), 128'(0));
    checkOutput("en_sticky",  128'(err_sticky), 128'(3'b101));

    // Saturation of the 4-bit sbit counter
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 8'(i), pat_5a, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat_14", 128'(sbit_cnt), 128'(4'hE));
    for (int i = 14; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), pat_5a, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat_20", 128'(sbit_cnt), 128'(4'hF));

    // Clear coincident with an error while LOGGED
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h01, pat_5a, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_first_addr", 128'(first_addr), 128'(8'h01));
    applyStimulus(1'b1, 8'hAA, pat_5a, 1'b0, 1'b1, 1'b0, 1'b1);
    checkCounts("clrev", 4'd0, 4'd1, 4'd0);
    checkOutput("clrev_first_addr", 128'(first_addr), 128'(8'hAA));
    checkOutput("clrev_first_type", 128'(first_type), 128'(2));
    checkOutput("clrev_sticky",     128'(err_sticky), 128'(3'b010));
    // Still LOGGED: capture frozen
    applyStimulus(1'b1, 8'hBB, pat_5a, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("logged_first_addr", 128'(first_addr), 128'(8'hAA));
    checkOutput("logged_first_type", 128'(first_type), 128'(2));
    checkOutput("logged_sbit_cnt",   128'(sbit_cnt),   128'(1));

    // Simultaneous flags and priority
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h3C, pat_5a, 1'b1, 1'b1, 1'b1, 1'b0);
    checkCounts("all3", 4'd1, 4'd1, 4'd1);
    checkOutput("all3_first_type", 128'(first_type), 128'(3));
    checkOutput("all3_sticky",     128'(err_sticky), 128'(3'b111));
    applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h40, pat_5a, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("sd_first_type", 128'(first_type), 128'(2));
    checkOutput("sd_first_addr", 128'(first_addr), 128'(8'h40));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
